// File: rtl/store_aligner.sv
// store_aligner: places a core store (SB/SH/SW) onto a 32-bit data-memory
// write port. Data is shifted into the correct byte lanes and byte strobes are
// generated. A store that crosses a word boundary is issued as two aligned
// beats. The core is held off through st_ready until the last beat is granted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid / st_ready   core store handshake (st_ready high only in IDLE)
//   st_funct3             3'b000 SB, 3'b001 SH, 3'b010 SW; anything else is illegal
//   st_addr, st_data      byte address and right-justified rs2 value
//   st_done               one-cycle pulse when the final beat is granted
//   st_err                one-cycle pulse after an illegal funct3 is accepted
//   mem_req/mem_gnt       write request; a beat completes when both are high
//   mem_addr              word-aligned write address
//   mem_wdata, mem_wstrb  lane-aligned write data and byte enables
module store_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t      state;
  logic [31:0] hi_data;  // upper half of the shifted data, used by BEAT1
  logic [3:0]  hi_strb;  // upper strobes; non-zero means the store splits

  logic        legal;
  logic [3:0]  mask;
  logic [31:0] data_m;
  logic [63:0] d64;
  logic [7:0]  s8;

  assign st_ready = (state == IDLE);

  always_comb begin
    legal  = 1'b1;
    mask   = '0;
    data_m = '0;
    case (st_funct3)
      3'b000: begin
        mask   = 4'b0001;
        data_m = {24'b0, st_data[7:0]};
      end
      3'b001: begin
        mask   = 4'b0011;
        data_m = {16'b0, st_data[15:0]};
      end
      3'b010: begin
        mask   = 4'b1111;
        data_m = st_data;
      end
      default: legal = 1'b0;
    endcase
    d64 = {32'b0, data_m} << {st_addr[1:0], 3'b000};
    s8  = {4'b0, mask} << st_addr[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_data   <= '0;
      hi_strb   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            if (legal) begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_wdata <= d64[31:0];
              mem_wstrb <= s8[3:0];
              hi_data   <= d64[63:32];
              hi_strb   <= s8[7:4];
            end else begin
              st_err <= 1'b1;
            end
          end
        end
        BEAT0: begin
          if (mem_gnt) begin
            if (hi_strb != '0) begin
              // mem_addr still holds the base here, so +4 gives the next word
              // and wraps naturally at the top of the address space.
              state     <= BEAT1;
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= hi_data;
              mem_wstrb <= hi_strb;
            end else begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              st_done   <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_gnt) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            st_done   <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
module tb_store_aligner;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;

  store_aligner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_done;
  int    exp_err;
  int    checks;
  int    failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    beat_t b;
    b.a = a;
    b.d = d;
    b.s = s;
    exp_beats.push_back(b);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          check("beat_addr", mem_addr, exp_beats[0].a);
          check("beat_wdata", mem_wdata, exp_beats[0].d);
          check("beat_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_beats[0].s});
          if (mem_gnt) void'(exp_beats.pop_front());
        end
      end else begin
        check("idle_bus_zero", mem_addr | mem_wdata | {28'b0, mem_wstrb}, 32'd0);
      end
      if (st_done) begin
        check("done_expected", (exp_done > 0) ? 32'd1 : 32'd0, 32'd1);
        check("done_after_last_beat", exp_beats.size(), 32'd0);
        if (exp_done > 0) exp_done--;
      end
      if (st_err) begin
        check("err_expected", (exp_err > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_err > 0) exp_err--;
      end
      if (st_done && st_err) check("done_err_exclusive", 32'd1, 32'd0);
    end
  end

  // Presents one store; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int unsigned n;
    n = 0;
    while (!st_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!st_ready) check("ready_timeout", 32'd0, 32'd1);
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    st_valid  = 1'b1;
    @(posedge clk);
    #1;
    st_valid  = 1'b0;
    st_funct3 = 3'b111;
    st_addr   = 32'hDEAD_BEE3;
    st_data   = 32'h5555_5555;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_done != 0 || exp_err != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", (exp_beats.size() == 0 && exp_done == 0 && exp_err == 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_done  = 0;
    exp_err   = 0;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_funct3 = 3'b000;
    st_addr   = '0;
    st_data   = '0;
    mem_gnt   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, st_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_bus", mem_addr | mem_wdata | {28'b0, mem_wstrb}, 32'd0);
    check("rst_done_err", {30'b0, st_done, st_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SB single beat with exact latency
    push_beat(32'h0000_1000, 32'h00AB_0000, 4'b0100);
    exp_done++;
    issue(3'b000, 32'h0000_1002, 32'hFFFF_FFAB);
    check("sb_req_n1", {31'b0, mem_req}, 32'd1);
    check("sb_ready_n1", {31'b0, st_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("sb_done_n2", {31'b0, st_done}, 32'd1);
    check("sb_ready_n2", {31'b0, st_ready}, 32'd1);
    wait_drain();

    // SH split at offset 3
    push_beat(32'h0000_1000, 32'h3400_0000, 4'b1000);
    push_beat(32'h0000_1004, 32'h0000_0012, 4'b0001);
    exp_done++;
    issue(3'b001, 32'h0000_1003, 32'h0000_1234);
    wait_drain();

    // SW split with beat0 stalled 3 cycles (monitor checks stability)
    mem_gnt = 1'b0;
    push_beat(32'h0000_2000, 32'hADBE_EF00, 4'b1110);
    push_beat(32'h0000_2004, 32'h0000_00DE, 4'b0001);
    exp_done++;
    issue(3'b010, 32'h0000_2001, 32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    #1;
    check("sw_stall_still_req", {31'b0, mem_req}, 32'd1);
    check("sw_stall_beats_left", exp_beats.size(), 32'd2);
    mem_gnt = 1'b1;
    wait_drain();

    // SW split with address wrap
    push_beat(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    push_beat(32'h0000_0000, 32'h0000_1122, 4'b0011);
    exp_done++;
    issue(3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
    wait_drain();

    // Illegal funct3 then back-to-back aligned SW
    exp_err++;
    issue(3'b011, 32'h0000_0040, 32'h1234_5678);
    check("err_pulse", {31'b0, st_err}, 32'd1);
    check("err_no_req", {31'b0, mem_req}, 32'd0);
    check("err_ready", {31'b0, st_ready}, 32'd1);
    push_beat(32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
    exp_done++;
    issue(3'b010, 32'h0000_0010, 32'hCAFE_F00D);
    check("err_one_cycle", {31'b0, st_err}, 32'd0);
    check("b2b_req", {31'b0, mem_req}, 32'd1);
    wait_drain();

    // Reset while stalled in the second beat
    push_beat(32'h0000_3000, 32'hD400_0000, 4'b1000);
    push_beat(32'h0000_3004, 32'h00A1_B2C3, 4'b0111);
    exp_done++;
    issue(3'b010, 32'h0000_3003, 32'hA1B2_C3D4);
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    @(posedge clk);
    #2;
    check("beat1_stalled_req", {31'b0, mem_req}, 32'd1);
    check("beat1_stalled_strb", {28'b0, mem_wstrb}, 32'h7);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, mem_req}, 32'd0);
    check("async_rst_ready", {31'b0, st_ready}, 32'd1);
    if (exp_beats.size() != 0) void'(exp_beats.pop_front());
    exp_done = 0;
    mem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ready", {31'b0, st_ready}, 32'd1);
    check("post_rst_req", {31'b0, mem_req}, 32'd0);
    check("post_rst_no_done", {31'b0, st_done}, 32'd0);
    check("final_queue_empty", exp_beats.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-side counterpart of the load data extender: accepts a store from the core (SB/SH/SW funct3, byte address, rs2 data) and drives it onto the word-wide data-memory write port.
- Shifts data into the correct byte lanes and generates byte strobes.
- Splits stores that straddle a word boundary into two aligned bus writes.
- Holds the core off with a ready/valid handshake until the write completes.

## Interface
- No parameters; data/address width fixed at 32, strobe width 4.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: core presents a store.
- `st_ready` out 1: block can accept a store; combinational, high exactly in IDLE.
- `st_funct3` in 3: 3'b000 SB, 3'b001 SH, 3'b010 SW; any other value is illegal.
- `st_addr` in 32: byte address.
- `st_data` in 32: rs2 value, right-justified.
- `st_done` out 1: one-cycle pulse when the final write beat is granted.
- `st_err` out 1: one-cycle pulse for an illegal funct3.
- `mem_req` out 1: write request.
- `mem_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_wstrb` out 4: byte enables; bit i enables lane i.
- `mem_gnt` in 1: memory accepts the current beat in any cycle where `mem_req` and `mem_gnt` are both high.

## Operation
- States:
  - IDLE: `st_ready=1`, `mem_req=0`.
  - BEAT0: first write.
  - BEAT1: second write, used only for split stores.
- Accept happens on a clock edge with `st_valid && st_ready`. At accept, latch:
  - off = `st_addr[1:0]`
  - base = `{st_addr[31:2],2'b00}`
  - mask = 4'b0001 (SB), 4'b0011 (SH), 4'b1111 (SW)
  - d64 = `{32'b0, st_data}` << (8·off); for SB/SH, `st_data` is first masked to 8 or 16 bits
  - s8 = `{4'b0, mask}` << off
- Transitions:
  - Legal funct3: IDLE → BEAT0.
  - Illegal funct3: stay in IDLE, pulse `st_err` in the next cycle, issue no memory access.
  - BEAT0 drives `mem_addr`=base, `mem_wdata`=d64[31:0], `mem_wstrb`=s8[3:0].
  - BEAT0 on grant: if s8[7:4]≠0, go to BEAT1; otherwise go to IDLE and pulse `st_done`.
  - BEAT1 drives `mem_addr`=base+4 (32-bit wrap: 0xFFFFFFFC+4 = 0x00000000), `mem_wdata`=d64[63:32], `mem_wstrb`=s8[7:4].
  - BEAT1 on grant: go to IDLE and pulse `st_done`.
- Split cases: SH with off=3; SW with off≠0. SB never splits.
- While `mem_req=0`, `mem_addr`, `mem_wdata` and `mem_wstrb` are all zero.
- While `mem_req=1`, all memory outputs stay stable until granted. There is no timeout.
- Core inputs are ignored outside the accept edge.

## Timing
- Memory-side outputs, `st_done` and `st_err` are registered.
- Reset (async assert):
  - state=IDLE.
  - `mem_req`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `st_done`, `st_err` = 0.
  - `st_ready`=1 during and after reset.
- Accept at edge N → `mem_req`=1 in cycle N+1.
- Single-beat store, grant in cycle N+1 → `st_done`=1 and `st_ready`=1 in cycle N+2.
- Minimum time between accepts: 2 cycles for single-beat stores, 3 for split stores.
- Each wait cycle with `mem_gnt`=0 adds one cycle of latency.
- `mem_gnt` high while `mem_req`=0 has no effect.
- Reset mid-operation: `mem_req` drops immediately (asynchronously), the in-flight store is abandoned, and no `st_done` is produced.
- `st_done` and `st_err` never assert in the same cycle.

## Test plan
- SB, addr 0x00001002, data 0xFFFFFFAB, `mem_gnt` tied high → single beat: addr 0x00001000, wdata 0x00AB0000, wstrb 4'b0100; `st_done` 2 cycles after accept.
- SH, addr 0x00001003, data 0x00001234 → beat0: 0x00001000 / 0x34000000 / 4'b1000; beat1: 0x00001004 / 0x00000012 / 4'b0001; one `st_done`.
- SW, addr 0x00002001, data 0xDEADBEEF, `mem_gnt` low for 3 cycles on beat0 → beat0 held stable: 0x00002000 / 0xADBEEF00 / 4'b1110; then beat1: 0x00002004 / 0x000000DE / 4'b0001.
- SW, addr 0xFFFFFFFE, data 0x11223344 → beat0: 0xFFFFFFFC / 0x33440000 / 4'b1100; beat1 wraps to 0x00000000 / 0x00001122 / 4'b0011.
- funct3 3'b011 → `st_err` pulses for 1 cycle, `mem_req` stays 0, `st_ready` is high the next cycle. Follow with back-to-back SW at 0x00000010 → aligned single beat, wstrb 4'b1111.
- Misaligned SW stalled in BEAT1 (`mem_gnt`=0) when `rst_n` asserts → `mem_req`=0 immediately, no `st_done`; after release, the block is in IDLE with `st_ready`=1.
